// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and framing constants,
// common to the receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  localparam int CLKS_PER_BIT_DEF = 217;  // 25 MHz / 115200 baud
  localparam int DATA_W           = 8;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset
// value is a parameter so an idle-high line does not look like an edge.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      dout <= RST_VAL;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_fe.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, framing
// error reporting and break hold-off until the line returns high.
module uart_rx_fe
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_serial,
  output logic              o_rx_dv,
  output logic [DATA_W-1:0] o_rx_byte,
  output logic              o_rx_busy,
  output logic              o_frame_err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic line;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (i_clk),
    .rst_n (i_rst),
    .din   (i_rx_serial),
    .dout  (line)
  );

  uart_state_e       state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [2:0]        bit_idx, idx_nxt;
  logic [DATA_W-1:0] shreg, sh_nxt;
  logic [DATA_W-1:0] byte_nxt;
  logic              dv_nxt, fe_nxt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      o_rx_byte   <= '0;
      o_rx_dv     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= idx_nxt;
      shreg       <= sh_nxt;
      o_rx_byte   <= byte_nxt;
      o_rx_dv     <= dv_nxt;
      o_frame_err <= fe_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = bit_idx;
    sh_nxt    = shreg;
    byte_nxt  = o_rx_byte;
    dv_nxt    = 1'b0;
    fe_nxt    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!line) state_nxt = START;
      end
      START: begin
        // Re-check the start bit at its mid-point; a high line was a glitch.
        if (cnt == HALF) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          state_nxt = line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_nxt = '0;
          sh_nxt[bit_idx] = line;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 idx_nxt   = bit_idx + 3'd1;
        end
      end
      STOP: begin
        // Leaving at the stop-bit mid-point lets a following start bit
        // be caught with no inter-frame gap.
        if (cnt == LAST) begin
          cnt_nxt = '0;
          if (line) begin
            byte_nxt  = shreg;
            dv_nxt    = 1'b1;
            state_nxt = IDLE;
          end else begin
            fe_nxt    = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_nxt = '0;
        if (line) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign o_rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fe.sv
// Self-checking bench for uart_rx_fe: directed scenarios plus random frames
// checked against a frame-level expectation model.
module tb_uart_rx_fe;

  localparam int PER = 217;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       dv, busy, fe;
  logic [7:0] rx_byte;

  int tests = 0;
  int fails = 0;

  uart_rx_fe #(.CLKS_PER_BIT(PER)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_serial (rx),
    .o_rx_dv     (dv),
    .o_rx_byte   (rx_byte),
    .o_rx_busy   (busy),
    .o_frame_err (fe)
  );

  always #5 clk = ~clk;

  // Monitor: posedge count, and everything observed on the outputs.
  int         cyc = 0;
  logic [7:0] dv_bytes[$];
  int         dv_cyc[$];
  int         fe_total = 0;
  int         viol = 0;
  int         busy_cyc = 0;
  logic       dv_prev = 1'b0, fe_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dv) begin
      dv_bytes.push_back(rx_byte);
      dv_cyc.push_back(cyc);
    end
    if (fe) fe_total++;
    if ((dv && fe) || (dv && dv_prev) || (fe && fe_prev)) viol++;
    if (busy) busy_cyc++;
    dv_prev = dv;
    fe_prev = fe;
  end

  // Model state: bytes the spec says must be delivered, and the held byte.
  logic [7:0] exp_q[$];
  int         exp_fe = 0;
  logic [7:0] exp_last = 8'h00;
  int         t_start = 0;

  task automatic idle(input int n);
    @(negedge clk) rx = 1'b1;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int per);
    @(negedge clk) rx = b;
    repeat (per - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int per);
    @(negedge clk) rx = 1'b0;
    t_start = cyc;
    repeat (per - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i], per);
    drive_bit(stop, per);
    if (stop) begin
      exp_q.push_back(d);
      exp_last = d;
    end else begin
      exp_fe++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (dv !== 1'b0)      begin fails++; $display("FAIL reset_dv got %b exp 0", dv); end
    tests++; if (rx_byte !== 8'h00) begin fails++; $display("FAIL reset_byte got %h exp 00", rx_byte); end
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (fe !== 1'b0)      begin fails++; $display("FAIL reset_fe got %b exp 0", fe); end
    rst = 1'b1;
    idle(10);
  endtask

  task automatic test_single();
    int n0 = dv_bytes.size();
    int f0 = fe_total;
    int lat;
    send_frame(8'h37, 1'b1, PER);
    idle(20);
    tests++;
    if (dv_bytes.size() != n0 + 1) begin
      fails++; $display("FAIL single_dv_count got %0d exp 1", dv_bytes.size() - n0);
    end else begin
      lat = dv_cyc[n0] - t_start;
      tests++; if (dv_bytes[n0] !== 8'h37) begin fails++; $display("FAIL single_byte got %h exp 37", dv_bytes[n0]); end
      tests++; if (lat < 2061 || lat > 2066) begin fails++; $display("FAIL single_latency got %0d exp 2061..2066", lat); end
    end
    tests++; if (rx_byte !== 8'h37)  begin fails++; $display("FAIL single_hold got %h exp 37", rx_byte); end
    tests++; if (fe_total != f0)     begin fails++; $display("FAIL single_fe got %0d exp 0", fe_total - f0); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL single_busy got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int n0 = dv_bytes.size();
    int gap;
    send_frame(8'h00, 1'b1, PER);
    send_frame(8'hFF, 1'b1, PER);
    idle(20);
    tests++;
    if (dv_bytes.size() != n0 + 2) begin
      fails++; $display("FAIL b2b_dv_count got %0d exp 2", dv_bytes.size() - n0);
    end else begin
      gap = dv_cyc[n0 + 1] - dv_cyc[n0];
      tests++; if (dv_bytes[n0] !== 8'h00)     begin fails++; $display("FAIL b2b_byte0 got %h exp 00", dv_bytes[n0]); end
      tests++; if (dv_bytes[n0 + 1] !== 8'hFF) begin fails++; $display("FAIL b2b_byte1 got %h exp ff", dv_bytes[n0 + 1]); end
      tests++; if (gap < 2165 || gap > 2175)   begin fails++; $display("FAIL b2b_spacing got %0d exp ~2170", gap); end
    end
  endtask

  task automatic test_glitch();
    int n0 = dv_bytes.size();
    int f0 = fe_total;
    int b0 = busy_cyc;
    int bc;
    @(negedge clk) rx = 1'b0;
    repeat (49) @(negedge clk);
    idle(200);
    bc = busy_cyc - b0;
    tests++; if (bc <= 0 || bc >= 115)     begin fails++; $display("FAIL glitch_busy_cycles got %0d exp 1..114", bc); end
    tests++; if (dv_bytes.size() != n0)     begin fails++; $display("FAIL glitch_dv got %0d exp 0", dv_bytes.size() - n0); end
    tests++; if (fe_total != f0)           begin fails++; $display("FAIL glitch_fe got %0d exp 0", fe_total - f0); end
    tests++; if (rx_byte !== exp_last)     begin fails++; $display("FAIL glitch_byte got %h exp %h", rx_byte, exp_last); end
  endtask

  task automatic test_break();
    int n0, f0, v0;
    send_frame(8'h5A, 1'b1, PER);
    idle(20);
    tests++; if (rx_byte !== 8'h5A) begin fails++; $display("FAIL brk_pre_byte got %h exp 5a", rx_byte); end
    n0 = dv_bytes.size();
    f0 = fe_total;
    v0 = viol;
    send_frame(8'hA5, 1'b0, PER);
    repeat (3000) @(negedge clk);
    tests++; if (busy !== 1'b1)        begin fails++; $display("FAIL brk_hold_busy got %b exp 1", busy); end
    tests++; if (fe_total != f0 + 1)   begin fails++; $display("FAIL brk_fe_count got %0d exp 1", fe_total - f0); end
    tests++; if (rx_byte !== 8'h5A)    begin fails++; $display("FAIL brk_byte got %h exp 5a", rx_byte); end
    tests++; if (dv_bytes.size() != n0) begin fails++; $display("FAIL brk_dv got %0d exp 0", dv_bytes.size() - n0); end
    idle(50);
    tests++; if (busy !== 1'b0)        begin fails++; $display("FAIL brk_exit_busy got %b exp 0", busy); end
    send_frame(8'h3C, 1'b1, PER);
    idle(20);
    tests++; if (dv_bytes.size() != n0 + 1 || rx_byte !== 8'h3C)
      begin fails++; $display("FAIL brk_next_byte got %h cnt %0d exp 3c cnt 1", rx_byte, dv_bytes.size() - n0); end
    tests++; if (fe_total != f0 + 1 || viol != v0)
      begin fails++; $display("FAIL brk_extra_pulses got fe %0d viol %0d exp 1 0", fe_total - f0, viol - v0); end
  endtask

  task automatic test_reset_mid();
    int n0 = dv_bytes.size();
    logic [7:0] d = 8'hC3;
    @(negedge clk) rx = 1'b0;
    repeat (PER - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(d[i], PER);
    @(negedge clk) rx = d[4];
    repeat (PER / 2) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_pre_busy got %b exp 1", busy); end
    #2 rst = 1'b0;
    rx = 1'b1;
    #1;
    exp_last = 8'h00;
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    tests++; if (rx_byte !== 8'h00)  begin fails++; $display("FAIL rstmid_byte got %h exp 00", rx_byte); end
    tests++; if (dv !== 1'b0 || fe !== 1'b0) begin fails++; $display("FAIL rstmid_pulses got %b%b exp 00", dv, fe); end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    idle(3 * PER);
    tests++; if (dv_bytes.size() != n0) begin fails++; $display("FAIL rstmid_aborted got %0d exp 0", dv_bytes.size() - n0); end
    send_frame(8'h81, 1'b1, PER);
    idle(20);
    tests++; if (dv_bytes.size() != n0 + 1 || rx_byte !== 8'h81)
      begin fails++; $display("FAIL rstmid_next got %h cnt %0d exp 81 cnt 1", rx_byte, dv_bytes.size() - n0); end
  endtask

  task automatic test_skew();
    int pers[2] = '{210, 224};
    for (int k = 0; k < 2; k++) begin
      int n0 = dv_bytes.size();
      int f0 = fe_total;
      send_frame(8'h96, 1'b1, pers[k]);
      idle(40);
      tests++;
      if (dv_bytes.size() != n0 + 1 || rx_byte !== 8'h96 || fe_total != f0)
        begin fails++; $display("FAIL skew_%0d got %h cnt %0d fe %0d exp 96 cnt 1 fe 0", pers[k], rx_byte, dv_bytes.size() - n0, fe_total - f0); end
    end
  endtask

  task automatic test_random();
    int n0 = dv_bytes.size();
    int e0 = exp_q.size();
    int f0 = fe_total;
    int ef0 = exp_fe;
    int v0 = viol;
    for (int k = 0; k < 12; k++) begin
      logic [7:0] d = 8'($urandom);
      logic stop = ($urandom_range(0, 3) != 0);
      int gap = stop ? $urandom_range(0, 200) : $urandom_range(10, 200);
      send_frame(d, stop, PER);
      if (gap > 0) idle(gap);
    end
    idle(30);
    tests++;
    if (dv_bytes.size() - n0 != exp_q.size() - e0) begin
      fails++; $display("FAIL rand_dv_count got %0d exp %0d", dv_bytes.size() - n0, exp_q.size() - e0);
    end else begin
      for (int i = 0; i < exp_q.size() - e0; i++) begin
        tests++;
        if (dv_bytes[n0 + i] !== exp_q[e0 + i])
          begin fails++; $display("FAIL rand_byte_%0d got %h exp %h", i, dv_bytes[n0 + i], exp_q[e0 + i]); end
      end
    end
    tests++; if (fe_total - f0 != exp_fe - ef0) begin fails++; $display("FAIL rand_fe_count got %0d exp %0d", fe_total - f0, exp_fe - ef0); end
    tests++; if (rx_byte !== exp_last)          begin fails++; $display("FAIL rand_hold got %h exp %h", rx_byte, exp_last); end
    tests++; if (viol != v0)                    begin fails++; $display("FAIL rand_pulse_rules got %0d exp 0", viol - v0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid();
    test_skew();
    test_random();
    tests++; if (viol != 0) begin fails++; $display("FAIL pulse_rules got %0d exp 0", viol); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
